stopwatch_ext: RTL and testbench
================================

STOPWATCH_EXT -- requirements
Module: stopwatch_ext

Interface
REQ-001 Parameter TICK_DIV, default 1, SHALL give CLK_100Hz cycles per 10 ms count tick (range 1..65535).
REQ-002 Parameter MAX_MIN, default 59, SHALL give the highest minute value before wrap (range 1..99).
REQ-003 CLK_100Hz  input  1  SHALL be the single clock; all flops on the rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high; clears all state.
REQ-005 start_stop  input  1  SHALL be a one-cycle pulse toggling run/pause.
REQ-006 clear  input  1  SHALL be a one-cycle pulse zeroing time and returning to IDLE.
REQ-007 down  input  1  SHALL select 0 = count up, 1 = count down; sampled only on the IDLE->RUN transition.
REQ-008 load  input  1  SHALL be a one-cycle pulse loading preset.
REQ-009 preset  input  16  SHALL be BCD {minute_g, minute_d, second_g, second_d}; centisecond digits load as 0.
REQ-010 ms_d, ms_g, second_d, second_g, minute_d, minute_g  output  4 each  SHALL be registered BCD digits (_d = units, _g = tens).
REQ-011 running  output  1  SHALL be high in RUN only.
REQ-012 done  output  1  SHALL be high in DONE only.
REQ-013 wrap  output  1  SHALL pulse one cycle on the up-count rollover.
REQ-014 lap  input  1, lap_time  output  24, lap_valid  output  1  SHALL exist only with STOPWATCH_LAP_EN.

Function
REQ-015 FSM states IDLE, RUN, PAUSE, DONE: IDLE->RUN on start_stop, except down=1 with time 00:00.00 (stays IDLE); RUN->PAUSE on start_stop; PAUSE->RUN on start_stop; DONE->IDLE on start_stop.
REQ-016 Per-cycle priority: clear > load > start_stop > tick; clear in any state SHALL zero all digits and the prescaler and go to IDLE.
REQ-017 Prescaler counts 0..TICK_DIV-1 only in RUN; tick = RUN and prescaler == TICK_DIV-1; prescaler holds in PAUSE and resets to 0 on IDLE->RUN and on clear; TICK_DIV=1 gives a tick every RUN cycle.
REQ-018 Up count per tick: ms_d 0-9, ms_g 0-9, second_d 0-9, second_g 0-5, minutes 00..MAX_MIN; full carry chain resolves on the tick edge.
REQ-019 Up count at MAX_MIN:59.99 SHALL go to 00:00.00 with wrap = 1 for that one cycle; state stays RUN.
REQ-020 Down count per tick: decrement with borrow (x0 seconds borrow to 59, 00.00 centiseconds borrow to 99); reaching 00:00.00 SHALL enter DONE on the same edge; never below zero.
REQ-021 load accepted in IDLE, PAUSE and DONE (DONE->IDLE), ignored in RUN; out-of-range digits clamp: any digit >9 -> 9, second_g >5 -> 5, minutes >MAX_MIN -> MAX_MIN.
REQ-022 start_stop and tick in the same RUN cycle: the tick SHALL be applied and state -> PAUSE.
REQ-023 Digits update only on tick, load or clear edges; otherwise they hold.

Reset
REQ-024 While reset is high: state IDLE, all digits 0, running/done/wrap 0, prescaler 0, lap_time 0, lap_valid 0, independent of the clock.
REQ-025 After reset release, no count SHALL occur until start_stop.

Configuration
REQ-026 STOPWATCH_LAP_EN defined: lap pulse in RUN or PAUSE SHALL capture the digit values present after that edge (including any same-cycle tick) into lap_time {minute_g..ms_d}, with lap_valid = 1 for one cycle; lap ignored in IDLE/DONE; clear zeroes lap_time; counting never disturbed.
REQ-027 STOPWATCH_LAP_EN undefined: lap, lap_time and lap_valid ports and logic absent; all other behaviour identical.

Verification
REQ-028 TICK_DIV=1, reset, start_stop, 6000 cycles -> 01:00.00, running=1, wrap never asserted.
REQ-029 TICK_DIV=4, start_stop, 40 cycles -> 00:00.10; start_stop, 100 cycles -> still 00:00.10; start_stop, 4 cycles -> 00:00.11.
REQ-030 down=1, preset 16'h0100, load, start_stop, 6000 ticks -> 00:00.00, done=1, running=0; further cycles -> no change.
REQ-031 MAX_MIN=59, preset 16'h5959, load, start_stop, 100 ticks -> 00:00.00, wrap high exactly one cycle, running=1.
REQ-032 LAP_EN, start at 00:00.00, lap at 00:12.34 -> lap_time=24'h001234, lap_valid one cycle, next tick 00:12.35.
REQ-033 reset asserted mid-RUN at 00:05.67, no clock edge -> all outputs 0 immediately; release -> stays 00:00.00 in IDLE.

Source files
------------

// File: rtl/stopwatch_ext.sv
// stopwatch_ext: BCD mm:ss.cc stopwatch with up/down counting, preset load and pause.
// Defining STOPWATCH_LAP_EN adds the lap input and the lap_time/lap_valid capture outputs.
module stopwatch_ext #(
  parameter int TICK_DIV = 1,
  parameter int MAX_MIN  = 59
) (
  input  logic        CLK_100Hz,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        down,
  input  logic        load,
  input  logic [15:0] preset,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic [23:0] lap_time,
  output logic        lap_valid,
`endif
  output logic [3:0]  ms_d,
  output logic [3:0]  ms_g,
  output logic [3:0]  second_d,
  output logic [3:0]  second_g,
  output logic [3:0]  minute_d,
  output logic [3:0]  minute_g,
  output logic        running,
  output logic        done,
  output logic        wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  MAX_G     = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_D     = 4'(MAX_MIN % 10);

  state_t      state, state_next;
  logic [15:0] presc, presc_next;
  logic        dir, dir_next;
  logic        wrap_next;
  logic [3:0]  ms_d_next, ms_g_next, second_d_next, second_g_next, minute_d_next, minute_g_next;
  logic [3:0]  p_mg, p_md, p_sg, p_sd;
  logic        tick, time_zero;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign tick      = (state == RUN) && (presc == TICK_LAST);
  assign time_zero = ({minute_g, minute_d, second_g, second_d, ms_g, ms_d} == 24'd0);
  assign running   = (state == RUN);
  assign done      = (state == DONE);

  always_comb begin
    state_next    = state;
    presc_next    = presc;
    dir_next      = dir;
    wrap_next     = 1'b0;
    ms_d_next     = ms_d;
    ms_g_next     = ms_g;
    second_d_next = second_d;
    second_g_next = second_g;
    minute_d_next = minute_d;
    minute_g_next = minute_g;

    // Preset digits are clamped per digit first, then the minute pair against MAX_MIN.
    p_mg = clamp9(preset[15:12]);
    p_md = clamp9(preset[11:8]);
    p_sg = (preset[7:4] > 4'd5) ? 4'd5 : preset[7:4];
    p_sd = clamp9(preset[3:0]);
    if ((p_mg > MAX_G) || ((p_mg == MAX_G) && (p_md > MAX_D))) begin
      p_mg = MAX_G;
      p_md = MAX_D;
    end

    if (clear) begin
      state_next    = IDLE;
      presc_next    = 16'd0;
      ms_d_next     = 4'd0;
      ms_g_next     = 4'd0;
      second_d_next = 4'd0;
      second_g_next = 4'd0;
      minute_d_next = 4'd0;
      minute_g_next = 4'd0;
    end else if (load && (state != RUN)) begin
      ms_d_next     = 4'd0;
      ms_g_next     = 4'd0;
      second_d_next = p_sd;
      second_g_next = p_sg;
      minute_d_next = p_md;
      minute_g_next = p_mg;
      if (state == DONE) state_next = IDLE;
    end else begin
      if (state == RUN) presc_next = tick ? 16'd0 : presc + 16'd1;

      if (tick && !dir) begin
        if (ms_d != 4'd9) ms_d_next = ms_d + 4'd1;
        else begin
          ms_d_next = 4'd0;
          if (ms_g != 4'd9) ms_g_next = ms_g + 4'd1;
          else begin
            ms_g_next = 4'd0;
            if (second_d != 4'd9) second_d_next = second_d + 4'd1;
            else begin
              second_d_next = 4'd0;
              if (second_g != 4'd5) second_g_next = second_g + 4'd1;
              else begin
                second_g_next = 4'd0;
                if ((minute_g == MAX_G) && (minute_d == MAX_D)) begin
                  minute_g_next = 4'd0;
                  minute_d_next = 4'd0;
                  wrap_next     = 1'b1;
                end else if (minute_d != 4'd9) minute_d_next = minute_d + 4'd1;
                else begin
                  minute_d_next = 4'd0;
                  minute_g_next = minute_g + 4'd1;
                end
              end
            end
          end
        end
      end else if (tick && dir) begin
        if (time_zero) state_next = DONE;
        else begin
          if (ms_d != 4'd0) ms_d_next = ms_d - 4'd1;
          else begin
            ms_d_next = 4'd9;
            if (ms_g != 4'd0) ms_g_next = ms_g - 4'd1;
            else begin
              ms_g_next = 4'd9;
              if (second_d != 4'd0) second_d_next = second_d - 4'd1;
              else begin
                second_d_next = 4'd9;
                if (second_g != 4'd0) second_g_next = second_g - 4'd1;
                else begin
                  second_g_next = 4'd5;
                  if (minute_d != 4'd0) minute_d_next = minute_d - 4'd1;
                  else begin
                    minute_d_next = 4'd9;
                    minute_g_next = minute_g - 4'd1;
                  end
                end
              end
            end
          end
          if ({minute_g_next, minute_d_next, second_g_next, second_d_next,
               ms_g_next, ms_d_next} == 24'd0) state_next = DONE;
        end
      end

      if (start_stop) begin
        case (state)
          IDLE: if (!(down && time_zero)) begin
            state_next = RUN;
            dir_next   = down;
            presc_next = 16'd0;
          end
          RUN:     if (state_next == RUN) state_next = PAUSE;
          PAUSE:   state_next = RUN;
          DONE:    state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_100Hz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= 16'd0;
      dir      <= 1'b0;
      wrap     <= 1'b0;
      ms_d     <= 4'd0;
      ms_g     <= 4'd0;
      second_d <= 4'd0;
      second_g <= 4'd0;
      minute_d <= 4'd0;
      minute_g <= 4'd0;
    end else begin
      state    <= state_next;
      presc    <= presc_next;
      dir      <= dir_next;
      wrap     <= wrap_next;
      ms_d     <= ms_d_next;
      ms_g     <= ms_g_next;
      second_d <= second_d_next;
      second_g <= second_g_next;
      minute_d <= minute_d_next;
      minute_g <= minute_g_next;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Capture uses the post-edge digits so a same-cycle tick is included.
  always_ff @(posedge CLK_100Hz or posedge reset) begin
    if (reset) begin
      lap_time  <= 24'd0;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_time  <= 24'd0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap && ((state == RUN) || (state == PAUSE));
      if (lap && ((state == RUN) || (state == PAUSE)))
        lap_time <= {minute_g_next, minute_d_next, second_g_next, second_d_next,
                     ms_g_next, ms_d_next};
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ext.sv
// Scoreboard bench for stopwatch_ext (TICK_DIV=4, MAX_MIN=59); lap checks build with STOPWATCH_LAP_EN.
module tb_stopwatch_ext;
  logic        clk = 1'b0, reset = 1'b0;
  logic        start_stop = 1'b0, clear = 1'b0, down = 1'b0, load = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic [3:0]  ms_d, ms_g, second_d, second_g, minute_d, minute_g;
  logic        running, done, wrap;
`ifdef STOPWATCH_LAP_EN
  logic        lap = 1'b0;
  logic [23:0] lap_time;
  logic        lap_valid;
`endif

  always #5 clk = ~clk;

  stopwatch_ext #(.TICK_DIV(4), .MAX_MIN(59)) dut (
    .CLK_100Hz(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .down(down), .load(load), .preset(preset),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_time(lap_time), .lap_valid(lap_valid),
`endif
    .ms_d(ms_d), .ms_g(ms_g), .second_d(second_d), .second_g(second_g),
    .minute_d(minute_d), .minute_g(minute_g),
    .running(running), .done(done), .wrap(wrap)
  );

  typedef struct {
    string       name;
    logic [23:0] t;
    logic        run, dn, wr;
    logic [23:0] lt;
    logic        lv;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0, wrap_cnt = 0;
  logic [23:0] exp_lap = 24'h0;
  event        smp;
  wire  [23:0] cur = {minute_g, minute_d, second_g, second_d, ms_g, ms_d};

  always @(negedge clk) if (wrap) wrap_cnt++;

  // Monitor: pops one expectation per sample point (negedge or explicit asynchronous sample).
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk or smp);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ok = (cur == e.t) && (running == e.run) && (done == e.dn) && (wrap == e.wr);
`ifdef STOPWATCH_LAP_EN
        ok = ok && (lap_time == e.lt) && (lap_valid == e.lv);
`endif
        checks++;
        if (!ok) begin
          errors++;
`ifdef STOPWATCH_LAP_EN
          $display("FAIL %s: got time=%h run=%b done=%b wrap=%b lap=%h/%b required time=%h run=%b done=%b wrap=%b lap=%h/%b",
                   e.name, cur, running, done, wrap, lap_time, lap_valid,
                   e.t, e.run, e.dn, e.wr, e.lt, e.lv);
`else
          $display("FAIL %s: got time=%h run=%b done=%b wrap=%b required time=%h run=%b done=%b wrap=%b",
                   e.name, cur, running, done, wrap, e.t, e.run, e.dn, e.wr);
`endif
        end else begin
          $display("ok   %s: time=%h run=%b done=%b wrap=%b", e.name, cur, running, done, wrap);
        end
      end
    end
  end

  task automatic push_lap(input string n, input logic [23:0] t, input logic r, d, w,
                          input logic [23:0] lt, input logic lv);
    exp_t e;
    e.name = n; e.t = t; e.run = r; e.dn = d; e.wr = w; e.lt = lt; e.lv = lv;
    sb.push_back(e);
  endtask

  task automatic push_exp(input string n, input logic [23:0] t, input logic r, d, w);
    push_lap(n, t, r, d, w, exp_lap, 1'b0);
  endtask

  task automatic check_int(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", n, act, req);
    end else begin
      $display("ok   %s: %0d", n, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
    exp_lap = 24'h0;
  endtask

  task automatic do_load(input logic [15:0] p);
    preset = p; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  initial begin
    // Asynchronous reset at power-up, sampled before any clock edge.
    #1 reset = 1'b1;
    #1 push_exp("reset_async", 24'h0, 0, 0, 0);
    -> smp;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    push_exp("idle_after_reset", 24'h0, 0, 0, 0);

    // Prescaler run / pause / resume.
    do_start(); cyc(40);  push_exp("run_40cyc",   24'h000010, 1, 0, 0);
    do_start(); cyc(100); push_exp("pause_hold",  24'h000010, 0, 0, 0);
    do_start(); cyc(4);   push_exp("resume_4cyc", 24'h000011, 1, 0, 0);
    do_clear();           push_exp("clear_run",   24'h0, 0, 0, 0);

    // One minute of up counting.
    wrap_cnt = 0;
    do_start(); cyc(24000);
    push_exp("one_minute", 24'h010000, 1, 0, 0);
    check_int("no_wrap_60s", wrap_cnt, 0);
    do_clear();

    // Down count: blocked at zero, then 01:00.00 to DONE.
    down = 1'b1;
    do_start();             push_exp("down_zero_idle", 24'h0, 0, 0, 0);
    do_load(16'h0100);      push_exp("load_0100",      24'h010000, 0, 0, 0);
    do_start(); down = 1'b0;
    cyc(4);                 push_exp("down_borrow",    24'h005999, 1, 0, 0);
    cyc(23995);             push_exp("down_last",      24'h000001, 1, 0, 0);
    cyc(1);                 push_exp("down_done",      24'h0, 0, 1, 0);
    cyc(20);                push_exp("done_hold",      24'h0, 0, 1, 0);
    do_start();             push_exp("done_to_idle",   24'h0, 0, 0, 0);

    // Preset clamping.
    do_load(16'h9999); push_exp("clamp_9999", 24'h595900, 0, 0, 0);
    do_load(16'h4A7C); push_exp("clamp_4A7C", 24'h495900, 0, 0, 0);
    do_load(16'h6000); push_exp("clamp_6000", 24'h590000, 0, 0, 0);

    // Up-count rollover at 59:59.99.
    do_load(16'h5959); push_exp("load_5959",    24'h595900, 0, 0, 0);
    do_start();
    cyc(399);          push_exp("pre_rollover", 24'h595999, 1, 0, 0);
    cyc(1);            push_exp("rollover",     24'h0, 1, 0, 1);
    cyc(1);            push_exp("wrap_drop",    24'h0, 1, 0, 0);
    cyc(3);            push_exp("after_wrap",   24'h000001, 1, 0, 0);

    // Load ignored in RUN, accepted in PAUSE; prescaler holds across the pause.
    do_load(16'h1234); push_exp("load_ign_run", 24'h000001, 1, 0, 0);
    do_start();        push_exp("pause",        24'h000001, 0, 0, 0);
    do_load(16'h1234); push_exp("load_pause",   24'h123400, 0, 0, 0);
    do_start(); cyc(2); push_exp("resume_presc", 24'h123401, 1, 0, 0);
    do_clear();

    // start_stop coinciding with a tick: tick applied, then paused.
    do_start(); cyc(3);
    do_start(); push_exp("ss_with_tick", 24'h000001, 0, 0, 0);
    do_clear();

    // clear beats load in the same cycle.
    do_load(16'h0100);
    preset = 16'h0200; clear = 1'b1; load = 1'b1; cyc(1); clear = 1'b0; load = 1'b0;
    push_exp("clear_over_load", 24'h0, 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
    // Lap capture at 00:12.34.
    do_start(); cyc(4936);
    push_exp("pre_lap", 24'h001234, 1, 0, 0);
    lap = 1'b1; cyc(1); lap = 1'b0;
    push_lap("lap_capture", 24'h001234, 1, 0, 0, 24'h001234, 1'b1);
    exp_lap = 24'h001234;
    cyc(1); push_exp("lap_valid_drop", 24'h001234, 1, 0, 0);
    cyc(2); push_exp("lap_next_tick",  24'h001235, 1, 0, 0);
    do_clear(); push_exp("clear_lap", 24'h0, 0, 0, 0);
`endif

    // Asynchronous reset in the middle of RUN at 00:05.67.
    do_start(); cyc(2268);
    push_exp("run_567", 24'h000567, 1, 0, 0);
    @(negedge clk); #1;
    reset = 1'b1; exp_lap = 24'h0;
    push_exp("reset_mid_run", 24'h0, 0, 0, 0);
    #1 -> smp;
    cyc(3);
    reset = 1'b0;
    cyc(10);
    push_exp("post_reset_idle", 24'h0, 0, 0, 0);

    cyc(3);
    check_int("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
